// File: rtl/lcd_pkg.sv
// Shared types and geometry for the LCD host: command codes, host FSM
// states and the image buffer dimensions.
package lcd_pkg;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int PIX_W  = 8;
  localparam int IMG_N  = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(IMG_N);

  typedef enum logic [2:0] {
    CMD_WRITE    = 3'd0,
    CMD_UP       = 3'd1,
    CMD_DOWN     = 3'd2,
    CMD_LEFT     = 3'd3,
    CMD_RIGHT    = 3'd4,
    CMD_AVG      = 3'd5,
    CMD_MIRROR_X = 3'd6,
    CMD_MIRROR_Y = 3'd7
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FINISHED  = 3'd5,
    ST_ERROR     = 3'd6
  } host_state_t;

  // Terminal states stop accepting new commands.
  function automatic logic is_terminal(host_state_t s);
    return (s == ST_FINISHED) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO for the command queue. Pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
// flush empties the queue in one cycle; it wins over a same-cycle push.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Read/write pointer update with synchronous reset and flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_cmd_host.sv
// Host-side partner of LCD_CTRL: queues commands, issues them one at a
// time on the cmd/cmd_valid/busy handshake, watches for end of frame and
// captures the controller's IRB write stream into a local 8x8 image.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | waiting for a queued command and controller not busy
// ST_ISSUE     | one-cycle cmd_valid strobe, queue head popped
// ST_WAIT_ACK  | waiting for controller to raise busy
// ST_WAIT_IDLE | non-write command running, waiting for busy to drop
// ST_WAIT_DONE | write command running, waiting for done
// ST_FINISHED  | frame written; terminal until reset
// ST_ERROR     | a wait state timed out; terminal until reset
module lcd_cmd_host
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        cq_data,
  input  logic              cq_valid,
  output logic              cq_ready,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  input  logic              IRB_RW,
  input  logic [5:0]        IRB_A,
  input  logic [7:0]        IRB_D,
  input  logic [5:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [6:0]        wr_count,
  output logic [13:0]       checksum,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  host_state_t      state;
  host_state_t      state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             load_tmr;
  logic             head_is_write;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic [2:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  logic [PIX_W-1:0] image [IMG_N];

  assign cq_ready   = !fifo_full && !is_terminal(state);
  assign fifo_push  = cq_valid && cq_ready;
  assign fifo_flush = (state == ST_FINISHED);

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (3)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (cq_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; acknowledgement beats timeout.
  always_comb begin
    state_nxt   = state;
    fifo_pop    = 1'b0;
    load_tmr    = 1'b0;
    cmd_valid   = 1'b0;
    cmd         = 3'd0;
    frame_done  = 1'b0;
    timeout_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !busy) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        cmd_valid = 1'b1;
        cmd       = fifo_dout;
        fifo_pop  = 1'b1;
        load_tmr  = 1'b1;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (busy) begin
          load_tmr  = 1'b1;
          state_nxt = head_is_write ? ST_WAIT_DONE : ST_WAIT_IDLE;
        end else if (tmr == '0) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_WAIT_IDLE: begin
        if (!busy)            state_nxt = ST_IDLE;
        else if (tmr == '0)   state_nxt = ST_ERROR;
      end
      ST_WAIT_DONE: begin
        if (done)             state_nxt = ST_FINISHED;
        else if (tmr == '0)   state_nxt = ST_ERROR;
      end
      ST_FINISHED: frame_done  = 1'b1;
      ST_ERROR:    timeout_err = 1'b1;
      default:     state_nxt   = ST_IDLE;
    endcase
  end

  // Wait-state timeout: down-counter loaded on entry, expires at zero.
  always_ff @(posedge clk) begin
    if (reset)            tmr <= '0;
    else if (load_tmr)    tmr <= TMR_W'(TIMEOUT - 1);
    else if (tmr != '0)   tmr <= tmr - 1'b1;
  end

  // Remember whether the issued command was a write to pick the wait path.
  always_ff @(posedge clk) begin
    if (reset)                  head_is_write <= 1'b0;
    else if (state == ST_ISSUE) head_is_write <= (fifo_dout == 3'(CMD_WRITE));
  end

  // Saturating count of issued commands.
  always_ff @(posedge clk) begin
    if (reset) issued_cnt <= '0;
    else if (state == ST_ISSUE && issued_cnt != {CNT_W{1'b1}})
      issued_cnt <= issued_cnt + 1'b1;
  end

  // IRB write statistics, active in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      checksum <= '0;
    end else if (!IRB_RW) begin
      if (wr_count != 7'd127) wr_count <= wr_count + 1'b1;
      checksum <= checksum + 14'(IRB_D);
    end
  end

  // Captured image; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!IRB_RW) image[IRB_A] <= IRB_D;
  end

  assign rd_data = image[rd_addr];

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed bench for lcd_cmd_host with a small LCD controller model that
// answers cmd_valid with busy (and the 64-byte write frame for CMD_WRITE).
module tb_lcd_cmd_host;

  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 255;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       cq_data = '0;
  logic             cq_valid = 1'b0;
  logic             cq_ready;
  logic [2:0]       cmd;
  logic             cmd_valid;
  logic             busy = 1'b0;
  logic             done = 1'b0;
  logic             IRB_RW = 1'b1;
  logic [5:0]       IRB_A = '0;
  logic [7:0]       IRB_D = '0;
  logic [5:0]       rd_addr = '0;
  logic [7:0]       rd_data;
  logic [CNT_W-1:0] issued_cnt;
  logic [6:0]       wr_count;
  logic [13:0]      checksum;
  logic             frame_done;
  logic             timeout_err;

  int total = 0;
  int bad   = 0;

  lcd_cmd_host #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cq_data     (cq_data),
    .cq_valid    (cq_valid),
    .cq_ready    (cq_ready),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .busy        (busy),
    .done        (done),
    .IRB_RW      (IRB_RW),
    .IRB_A       (IRB_A),
    .IRB_D       (IRB_D),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .issued_cnt  (issued_cnt),
    .wr_count    (wr_count),
    .checksum    (checksum),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Controller model and pulse monitor, both on the falling edge.
  logic       model_en  = 1'b0;
  int         model_lat = 2;
  int         m_phase   = 0;
  int         m_cnt     = 0;
  int         m_a       = 0;
  logic [2:0] m_cmd     = '0;
  int         pulse_cmd [$];
  int         pulse_cyc [$];
  int         neg_cnt   = 0;
  int         busy_viol = 0;

  always @(negedge clk) begin
    neg_cnt++;
    if (cmd_valid === 1'b1) begin
      pulse_cmd.push_back(int'(cmd));
      pulse_cyc.push_back(neg_cnt);
      if (busy) busy_viol++;
    end
    if (!model_en) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (cmd_valid === 1'b1) begin m_cmd = cmd; m_phase = 1; end
        1: begin
          busy = 1'b1;
          if (m_cmd == 3'd0) begin m_a = 0; m_phase = 2; end
          else begin m_cnt = model_lat - 1; m_phase = 3; end
        end
        2: begin
          IRB_RW = 1'b0; IRB_A = 6'(m_a); IRB_D = 8'(m_a);
          m_a++;
          if (m_a == 64) m_phase = 4;
        end
        3: if (m_cnt == 0) begin busy = 1'b0; m_phase = 0; end else m_cnt--;
        4: begin IRB_RW = 1'b1; done = 1'b1; m_phase = 5; end
        5: begin done = 1'b0; busy = 1'b0; m_phase = 0; end
        default: m_phase = 0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic busy_init);
    model_en = 1'b0;
    @(negedge clk);
    reset = 1'b1; cq_valid = 1'b0; IRB_RW = 1'b1; done = 1'b0; busy = busy_init;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_cmd.delete();
    pulse_cyc.delete();
    busy_viol = 0;
  endtask

  task automatic push(input logic [2:0] d, output logic acc);
    cq_data = d; cq_valid = 1'b1;
    acc = cq_ready;
    @(negedge clk);
    cq_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, output logic ok);
    for (int i = 0; i < budget && pulse_cmd.size() < n; i++) @(negedge clk);
    ok = (pulse_cmd.size() >= n);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++; if (cq_ready !== 1'b1) begin bad++; $display("FAIL reset_cq_ready: got %0b want 1", cq_ready); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid: got %0b want 0", cmd_valid); end
    total++; if (cmd !== 3'd0) begin bad++; $display("FAIL reset_cmd: got %0d want 0", cmd); end
    total++; if (issued_cnt !== '0) begin bad++; $display("FAIL reset_issued: got %0d want 0", issued_cnt); end
    total++; if (wr_count !== 7'd0) begin bad++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    total++; if (checksum !== 14'd0) begin bad++; $display("FAIL reset_checksum: got %0d want 0", checksum); end
    total++; if (frame_done !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL reset_flags: got fd=%0b te=%0b want 0 0", frame_done, timeout_err); end
  endtask

  task automatic test_busy_hold();
    logic acc, ok;
    do_reset(1'b1);
    push(3'd1, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL hold_push: got %0b want 1", acc); end
    repeat (70) @(negedge clk);
    total++; if (pulse_cmd.size() != 0) begin bad++; $display("FAIL hold_no_issue: got %0d pulses want 0", pulse_cmd.size()); end
    busy = 1'b0; model_lat = 2; model_en = 1'b1;
    wait_pulses(1, 20, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL hold_issue_timeout: got %0d pulses want 1", pulse_cmd.size()); end
    repeat (10) @(negedge clk);
    total++; if (pulse_cmd.size() != 1 || pulse_cmd[0] != 1) begin bad++; $display("FAIL hold_cmd: got n=%0d cmd=%0d want n=1 cmd=1", pulse_cmd.size(), (pulse_cmd.size() > 0) ? pulse_cmd[0] : -1); end
    total++; if (issued_cnt !== 8'd1) begin bad++; $display("FAIL hold_issued: got %0d want 1", issued_cnt); end
  endtask

  task automatic test_sequence();
    logic acc, ok;
    int exp_cmd [4] = '{3, 4, 5, 6};
    do_reset(1'b0);
    model_lat = 2; model_en = 1'b1;
    for (int i = 0; i < 4; i++) push(3'(exp_cmd[i]), acc);
    wait_pulses(4, 200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL seq_count: got %0d pulses want 4", pulse_cmd.size()); end
    repeat (10) @(negedge clk);
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (pulse_cmd[i] != exp_cmd[i]) begin bad++; $display("FAIL seq_cmd[%0d]: got %0d want %0d", i, pulse_cmd[i], exp_cmd[i]); end
      end
      for (int i = 1; i < 4; i++) begin
        total++; if (pulse_cyc[i] - pulse_cyc[i-1] < 4) begin bad++; $display("FAIL seq_spacing[%0d]: got %0d want >=4", i, pulse_cyc[i] - pulse_cyc[i-1]); end
      end
    end
    total++; if (busy_viol != 0) begin bad++; $display("FAIL seq_valid_while_busy: got %0d want 0", busy_viol); end
    total++; if (issued_cnt !== 8'd4) begin bad++; $display("FAIL seq_issued: got %0d want 4", issued_cnt); end
  endtask

  task automatic test_frame();
    logic acc;
    do_reset(1'b0);
    model_en = 1'b1;
    push(3'd0, acc);
    for (int i = 0; i < 300 && frame_done !== 1'b1; i++) @(negedge clk);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL frame_done: got %0b want 1", frame_done); end
    total++; if (wr_count !== 7'd64) begin bad++; $display("FAIL frame_wr_count: got %0d want 64", wr_count); end
    total++; if (checksum !== 14'd2016) begin bad++; $display("FAIL frame_checksum: got %0d want 2016", checksum); end
    total++; if (cq_ready !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL frame_flags: got rdy=%0b te=%0b want 0 0", cq_ready, timeout_err); end
    rd_addr = 6'd37; #1;
    total++; if (rd_data !== 8'd37) begin bad++; $display("FAIL frame_rd37: got %0d want 37", rd_data); end
    rd_addr = 6'd0; #1;
    total++; if (rd_data !== 8'd0) begin bad++; $display("FAIL frame_rd0: got %0d want 0", rd_data); end
    rd_addr = 6'd63; #1;
    total++; if (rd_data !== 8'd63) begin bad++; $display("FAIL frame_rd63: got %0d want 63", rd_data); end
  endtask

  task automatic test_timeout();
    logic acc;
    int k;
    do_reset(1'b0);
    push(3'd2, acc);
    for (int i = 0; i < 20 && cmd_valid !== 1'b1; i++) @(negedge clk);
    total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL to_issue: got %0b want 1", cmd_valid); end
    k = 0;
    while (timeout_err !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    total++; if (k != TIMEOUT + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", k, TIMEOUT + 1); end
    total++; if (cq_ready !== 1'b0) begin bad++; $display("FAIL to_cq_ready: got %0b want 0", cq_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL to_frame_done: got %0b want 0", frame_done); end
  endtask

  task automatic test_fifo_full();
    logic acc, ok;
    int vals [9] = '{1, 2, 3, 4, 5, 6, 7, 1, 2};
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      push(3'(vals[i]), acc);
      total++; if (acc !== (i < 8)) begin bad++; $display("FAIL full_accept[%0d]: got %0b want %0b", i, acc, (i < 8)); end
      if (i == 7) begin
        total++; if (cq_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", cq_ready); end
      end
    end
    busy = 1'b0; model_lat = 2; model_en = 1'b1;
    wait_pulses(8, 300, ok);
    repeat (30) @(negedge clk);
    total++; if (pulse_cmd.size() != 8) begin bad++; $display("FAIL full_pulses: got %0d want 8", pulse_cmd.size()); end
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (pulse_cmd[i] != vals[i]) begin bad++; $display("FAIL full_order[%0d]: got %0d want %0d", i, pulse_cmd[i], vals[i]); end
      end
    end
    total++; if (issued_cnt !== 8'd8) begin bad++; $display("FAIL full_issued: got %0d want 8", issued_cnt); end
  endtask

  task automatic test_reset_mid();
    logic acc;
    do_reset(1'b0);
    model_en = 1'b1;
    push(3'd0, acc);
    push(3'd5, acc);
    push(3'd6, acc);
    for (int i = 0; i < 100 && wr_count < 7'd10; i++) @(negedge clk);
    total++; if (wr_count < 7'd10 || frame_done !== 1'b0) begin bad++; $display("FAIL mid_setup: got wr=%0d fd=%0b want >=10 0", wr_count, frame_done); end
    model_en = 1'b0;
    @(negedge clk);
    reset = 1'b1; busy = 1'b0; IRB_RW = 1'b1; done = 1'b0;
    @(negedge clk);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL mid_frame_done: got %0b want 0", frame_done); end
    total++; if (issued_cnt !== '0) begin bad++; $display("FAIL mid_issued: got %0d want 0", issued_cnt); end
    total++; if (wr_count !== 7'd0 || checksum !== 14'd0) begin bad++; $display("FAIL mid_irb: got wr=%0d cs=%0d want 0 0", wr_count, checksum); end
    total++; if (cq_ready !== 1'b1) begin bad++; $display("FAIL mid_cq_ready: got %0b want 1", cq_ready); end
    reset = 1'b0;
    pulse_cmd.delete();
    pulse_cyc.delete();
    repeat (15) @(negedge clk);
    total++; if (pulse_cmd.size() != 0) begin bad++; $display("FAIL mid_fifo_empty: got %0d pulses want 0", pulse_cmd.size()); end
  endtask

  initial begin
    test_reset();
    test_busy_hold();
    test_sequence();
    test_frame();
    test_timeout();
    test_fifo_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_host.md
Name: lcd_cmd_host

Overview:
- Host-side partner of the LCD controller.
- Queues 3-bit commands from upstream and issues them on the cmd/cmd_valid/busy handshake, one at a time.
- Detects end of frame via done, and captures the controller's image-result-buffer write stream (IRB_RW/IRB_A/IRB_D) into a local 64x8 image with a running checksum.
- Sits between the test/host logic and LCD_CTRL, and also serves as the IRB responder.

Parameters:
- FIFO_DEPTH, 8, command queue entries (power of 2, ≥2)
- TIMEOUT, 255, max cycles in any wait state before error
- CNT_W, 8, width of issued-command counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cq_data  in  3  command to enqueue (0=write,1=up,2=down,3=left,4=right,5=avg,6=mirX,7=mirY)
- cq_valid  in  1  enqueue request
- cq_ready  out  1  queue can accept (= !full && state!=FINISHED/ERROR)
- cmd  out  3  command to controller
- cmd_valid  out  1  one-cycle command strobe
- busy  in  1  controller busy
- done  in  1  controller frame written
- IRB_RW  in  1  0 = write cycle
- IRB_A  in  6  write address
- IRB_D  in  8  write data
- rd_addr  in  6  local image read address
- rd_data  out  8  local image byte, combinational from rd_addr
- issued_cnt  out  CNT_W  commands issued, saturating
- wr_count  out  7  IRB write cycles seen, saturating at 127
- checksum  out  14  sum of IRB_D over write cycles, mod 2^14
- frame_done  out  1  high in FINISHED
- timeout_err  out  1  high in ERROR

Behaviour:
- Reset values:
  - State, FIFO pointers, issued_cnt, wr_count, checksum, cmd, cmd_valid, frame_done, timeout_err all reset to 0.
  - Image contents are not reset.
- FIFO:
  - Push when cq_valid && cq_ready.
  - Pop in ISSUE.
  - Push while full is refused even if a pop occurs the same cycle.
  - Push and pop when not full both take effect.
- FSM:
  - IDLE: wait for FIFO non-empty && busy==0. Controller busy is 1 during its post-reset IROM load, so no issue happens until it drops. When both hold → ISSUE.
  - ISSUE: cmd_valid=1 and cmd=FIFO head for exactly this one cycle. Pop the FIFO, increment issued_cnt → WAIT_ACK.
  - WAIT_ACK: cmd_valid=0, wait for busy==1.
    - If the head was 0 → WAIT_DONE.
    - Otherwise → WAIT_IDLE.
  - WAIT_IDLE: wait for busy==0 → IDLE.
  - WAIT_DONE: wait for done==1 → FINISHED.
  - FINISHED: terminal until reset. frame_done=1, cq_ready=0, remaining queue entries are discarded.
  - ERROR: terminal until reset. timeout_err=1, cq_ready=0.
- Timeout:
  - Cycle counter clears on entry to WAIT_ACK, WAIT_IDLE and WAIT_DONE.
  - Reaching TIMEOUT in any of them → ERROR.
  - TIMEOUT must exceed the 66-cycle write frame.
- Issue spacing:
  - Minimum 4 cycles between cmd_valid pulses: ISSUE, WAIT_ACK ≥1, WAIT_IDLE ≥1, IDLE.
  - cmd_valid is never asserted while busy==1.
- IRB capture:
  - Active in every state.
  - On a posedge with IRB_RW==0: image[IRB_A] <= IRB_D, wr_count++ (saturating at 127), checksum += IRB_D.
  - Repeated addresses overwrite the byte and are counted again.
- Reset mid-operation: everything returns to IDLE/0 in the next cycle, and the FIFO is emptied.

Decomposition:
- Shared package lcd_pkg:
  - cmd_t enum (CMD_WRITE..CMD_MIRROR_Y = 0..7)
  - host state enum
  - IMG_W=8, IMG_H=8, PIX_W=8
- Sub-module lcd_cmd_fifo: parameterised sync FIFO with full/empty flags.
- The FSM and capture buffer stay in lcd_cmd_host.

Test Plan:
- Busy held 1 for 70 cycles after reset, queue {1} → cmd_valid stays 0 until busy falls. Then one pulse with cmd=1, issued_cnt=1.
- Queue {3,4,5,6}, controller model busy for 2 cycles per command → four pulses with cmd 3,4,5,6, each ≥4 cycles apart, and never while busy.
- Queue {0}, model writes image[a]=a for a=0..63 then asserts done → frame_done=1, wr_count=64, checksum=2016, rd_addr=37 gives rd_data=37.
- Model never raises busy after cmd_valid → timeout_err=1 exactly TIMEOUT cycles after entering WAIT_ACK, cq_ready=0.
- Push 9 entries with FIFO_DEPTH=8 while busy=1 → cq_ready=0 after the 8th push. The 9th is not accepted; entries 1-8 are issued in order.
- Reset asserted in WAIT_DONE → next cycle state IDLE, frame_done=0, issued_cnt=0, FIFO empty.
